dcache_miss_ctrl: RTL

Miss controller for the two-port, 2-way set-associative data cache in the M stage of the dual-issue pipeline. Each cycle it checks both memory-stage ports for a miss and stalls the pipeline when one is found. It picks one miss at a time, runs the block read to main memory, and pulses the cache's `READY` for exactly one cycle so the cache performs its negedge refill. It also counts misses and flags memory transactions that never complete.

---
 rtl/dcache_miss_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/dcache_miss_ctrl.sv
module dcache_miss_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  input  logic             hit1,
  input  logic             hit2,
  input  logic [31:0]      a1,
  input  logic [31:0]      a2,
  input  logic             mem_gnt,
  input  logic             mem_valid,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             ready,
  output logic             stall,
  output logic             svc_port,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             timeout_err
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt;
  logic            m1, m2;
  logic            svc_req;
  logic            abort;
  logic            unused_bits;

  assign m1          = req1 & ~hit1;
  assign m2          = req2 & ~hit2;
  assign svc_req     = svc_port ? req2 : req1;
  assign stall       = (state_q != S_IDLE) | m1 | m2;
  assign unused_bits = ^{a1[5:0], a2[5:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ready is decoded from FILL so a port that dropped its request mid-miss
  // sees no refill strobe, while the transaction itself still completes.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    ready   = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (m1 || m2) state_d = S_REQ;
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          state_d = S_FILL;
        end else if (to_cnt == TO_LAST) begin
          state_d = S_IDLE;
          abort   = 1'b1;
        end
      end
      S_FILL: begin
        ready   = svc_req;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr    <= '0;
      svc_port    <= 1'b0;
      to_cnt      <= '0;
      miss_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        if (m1) begin
          svc_port <= 1'b0;
          mem_addr <= {a1[31:6], 6'b0};
        end else if (m2) begin
          svc_port <= 1'b1;
          mem_addr <= {a2[31:6], 6'b0};
        end
      end
      to_cnt <= (state_q == S_WAIT) ? to_cnt + 1'b1 : '0;
      if (abort) timeout_err <= 1'b1;
      if (ready && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule
